// File: rtl/key_search_controller.sv
// Sweeps the key space in batches of NUM_CORES keys, one per decryptor core, stopping on the first passing key.
// Optional feature macro: KEY_SEARCH_RESUME_EN adds a resume input that continues the search past a found key.
module key_search_controller #(
   parameter int                   NUM_CORES = 4,
   parameter int                   KEY_WIDTH = 24,
   parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic                           abort,
`ifdef KEY_SEARCH_RESUME_EN
   input  logic                           resume,
`endif
   output logic [NUM_CORES-1:0]           core_start,
   output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
   input  logic [NUM_CORES-1:0]           core_finish,
   input  logic [NUM_CORES-1:0]           core_fail,
   output logic                           busy,
   output logic                           found,
   output logic                           exhausted,
   output logic [KEY_WIDTH-1:0]           found_key,
   output logic [KEY_WIDTH-1:0]           current_key,
   output logic [2:0]                     state_dbg
);

   // One extra bit so base+offset past an all-ones KEY_MAX compares as larger instead of wrapping.
   localparam int EW = KEY_WIDTH + 1;
   typedef logic [EW-1:0] ext_t;
   localparam ext_t KEY_MAX_X = {1'b0, KEY_MAX};
   localparam ext_t STEP      = ext_t'(NUM_CORES);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT      = 3'd2,
      S_CHECK     = 3'd3,
      S_FOUND     = 3'd4,
      S_EXHAUSTED = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   ext_t                   base_q, base_d, base_step;
   logic                   past_max;
   logic [NUM_CORES-1:0]   done_q, done_d, fail_q, fail_d;
   logic [NUM_CORES-1:0]   done_cap, fail_cap;
   logic                   found_d, exhausted_d;
   logic [KEY_WIDTH-1:0]   found_key_d;
   logic                   launch;
   logic                   any_pass;
   ext_t                   win_sum;
   ext_t                   lane_sum [NUM_CORES];
   logic [NUM_CORES*KEY_WIDTH-1:0] lane_keys;
   logic [NUM_CORES-1:0]   lane_mask;

   assign base_step   = base_q + STEP;
   assign past_max    = (base_step > KEY_MAX_X);
   assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_CHECK);
   assign current_key = base_q[KEY_WIDTH-1:0];
   assign state_dbg   = state_q;

   // Core handshake: core_start[i] is a one-cycle request carrying core_key[i]; the core answers by
   // raising core_finish[i] (pulse or level) with core_fail[i] valid in that same cycle. The first
   // finish seen in WAIT latches done/fail; later finish cycles of that core are ignored until relaunch.
   always_comb begin
      done_cap = done_q | core_finish;
      fail_cap = fail_q;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (!done_q[i] && core_finish[i]) fail_cap[i] = core_fail[i];
      end
   end

   // Lowest-index passing core wins.
   always_comb begin
      any_pass = 1'b0;
      win_sum  = base_q;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (done_q[i] && !fail_q[i]) begin
            any_pass = 1'b1;
            win_sum  = base_q + ext_t'(i);
         end
      end
   end

   always_comb begin
      lane_sum  = '{default: '0};
      lane_keys = '0;
      lane_mask = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         lane_sum[i] = base_d + ext_t'(i);
         lane_keys[i*KEY_WIDTH +: KEY_WIDTH] = lane_sum[i][KEY_WIDTH-1:0];
         lane_mask[i] = (lane_sum[i] <= KEY_MAX_X);
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      done_d      = done_q;
      fail_d      = fail_q;
      found_d     = found;
      exhausted_d = exhausted;
      found_key_d = found_key;
      launch      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LAUNCH;
               base_d      = '0;
               found_d     = 1'b0;
               exhausted_d = 1'b0;
               launch      = 1'b1;
            end
         end
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT: begin
            done_d = done_cap;
            fail_d = fail_cap;
            if (&done_cap) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (any_pass) begin
               state_d     = S_FOUND;
               found_d     = 1'b1;
               found_key_d = win_sum[KEY_WIDTH-1:0];
            end else if (past_max) begin
               state_d     = S_EXHAUSTED;
               exhausted_d = 1'b1;
            end else begin
               state_d = S_LAUNCH;
               base_d  = base_step;
               launch  = 1'b1;
            end
         end
         S_FOUND: begin
            if (start) begin
               state_d = S_IDLE;
               found_d = 1'b0;
            end
`ifdef KEY_SEARCH_RESUME_EN
            else if (resume) begin
               found_d = 1'b0;
               if (past_max) begin
                  state_d     = S_EXHAUSTED;
                  exhausted_d = 1'b1;
               end else begin
                  state_d = S_LAUNCH;
                  base_d  = base_step;
                  launch  = 1'b1;
               end
            end
`endif
         end
         S_EXHAUSTED: begin
            if (start) begin
               state_d     = S_IDLE;
               exhausted_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d     = S_IDLE;
         base_d      = base_q;
         done_d      = '0;
         fail_d      = '0;
         found_d     = 1'b0;
         exhausted_d = 1'b0;
         found_key_d = found_key;
         launch      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Cores past KEY_MAX are never started and count as finished-and-failed from launch onwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q     <= '0;
         done_q     <= '0;
         fail_q     <= '0;
         core_start <= '0;
         core_key   <= '0;
         found      <= 1'b0;
         exhausted  <= 1'b0;
         found_key  <= '0;
      end else begin
         base_q     <= base_d;
         done_q     <= launch ? ~lane_mask : done_d;
         fail_q     <= launch ? ~lane_mask : fail_d;
         core_start <= launch ? lane_mask : '0;
         if (launch) core_key <= lane_keys;
         found      <= found_d;
         exhausted  <= exhausted_d;
         found_key  <= found_key_d;
      end
   end

endmodule

// File: tb/tb_key_search_controller.sv
// Directed bench: instance A (4 cores, KEY_MAX=11) and instance B (3 cores, 4-bit keys, KEY_MAX all-ones).
// Expected launches are queued when stimulus is driven and checked whenever a DUT pulses core_start.
module tb_key_search_controller;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LAUNCH = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_CHECK  = 3'd3;
   localparam logic [2:0] ST_FOUND  = 3'd4;
   localparam logic [2:0] ST_EXH    = 3'd5;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- instance A ----------------
   logic        start_a, abort_a;
   logic [3:0]  core_start_a, finish_a, fail_a;
   logic [95:0] core_key_a;
   logic        busy_a, found_a, exh_a;
   logic [23:0] found_key_a, current_key_a;
   logic [2:0]  state_a;
`ifdef KEY_SEARCH_RESUME_EN
   logic        resume_a;
   logic        resume_b;
`endif

   key_search_controller #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MAX(24'd11)) u_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
`ifdef KEY_SEARCH_RESUME_EN
      .resume(resume_a),
`endif
      .core_start(core_start_a), .core_key(core_key_a),
      .core_finish(finish_a), .core_fail(fail_a),
      .busy(busy_a), .found(found_a), .exhausted(exh_a),
      .found_key(found_key_a), .current_key(current_key_a), .state_dbg(state_a)
   );

   // ---------------- instance B ----------------
   logic        start_b, abort_b;
   logic [2:0]  core_start_b, finish_b, fail_b;
   logic [11:0] core_key_b;
   logic        busy_b, found_b, exh_b;
   logic [3:0]  found_key_b, current_key_b;
   logic [2:0]  state_b;

   key_search_controller #(.NUM_CORES(3), .KEY_WIDTH(4), .KEY_MAX(4'hF)) u_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
`ifdef KEY_SEARCH_RESUME_EN
      .resume(resume_b),
`endif
      .core_start(core_start_b), .core_key(core_key_b),
      .core_finish(finish_b), .core_fail(fail_b),
      .busy(busy_b), .found(found_b), .exhausted(exh_b),
      .found_key(found_key_b), .current_key(current_key_b), .state_dbg(state_b)
   );

   // ---------------- scoreboard ----------------
   logic [99:0] exp_a_q[$];
   logic [14:0] exp_b_q[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [99:0] exp_a(input int base);
      logic [95:0] k;
      logic [3:0]  m;
      for (int i = 0; i < 4; i++) begin
         k[i*24 +: 24] = 24'(base + i);
         m[i] = ((base + i) <= 11);
      end
      return {k, m};
   endfunction

   function automatic logic [2:0] mask_b(input int base);
      logic [2:0] m;
      for (int i = 0; i < 3; i++) m[i] = ((base + i) <= 15);
      return m;
   endfunction

   function automatic logic [14:0] exp_b(input int base);
      logic [11:0] k;
      for (int i = 0; i < 3; i++) k[i*4 +: 4] = 4'(base + i);
      return {k, mask_b(base)};
   endfunction

   always @(negedge clk) begin
      if (core_start_a !== 4'd0) begin
         if (exp_a_q.size() == 0) chk("launch_a_unexpected", {96'd0, core_start_a}, 128'd0);
         else chk("launch_a", {core_key_a, core_start_a}, exp_a_q.pop_front());
      end
      if (core_start_b !== 3'd0) begin
         if (exp_b_q.size() == 0) chk("launch_b_unexpected", {12'd0, core_start_b}, 128'd0);
         else chk("launch_b", {core_key_b, core_start_b}, exp_b_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic a_start();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
   endtask

   task automatic a_finish(input logic [3:0] which, input logic [3:0] fail);
      @(negedge clk) begin finish_a = which; fail_a = fail; end
      @(negedge clk) begin finish_a = 4'd0; fail_a = 4'd0; end
   endtask

   task automatic b_start();
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
   endtask

   task automatic b_finish(input logic [2:0] which, input logic [2:0] fail);
      @(negedge clk) begin finish_b = which; fail_b = fail; end
      @(negedge clk) begin finish_b = 3'd0; fail_b = 3'd0; end
   endtask

   task automatic chk_a_zero(input string tag);
      chk(tag, {core_start_a, core_key_a, busy_a, found_a, exh_a, found_key_a, current_key_a, state_a}, 128'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; finish_a = '0; fail_a = '0;
      start_b = 1'b0; abort_b = 1'b0; finish_b = '0; fail_b = '0;
`ifdef KEY_SEARCH_RESUME_EN
      resume_a = 1'b0; resume_b = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk_a_zero("reset_a");
      chk("reset_b", {core_start_b, core_key_b, busy_b, found_b, exh_b, found_key_b, current_key_b, state_b}, 128'd0);
      reset_n = 1'b1;

      // Reset in the middle of WAIT, then relaunch from key 0.
      exp_a_q.push_back(exp_a(0));
      a_start();
      chk("first_launch_state", state_a, ST_LAUNCH);
      chk("first_launch_busy", busy_a, 1'b1);
      @(negedge clk);
      a_finish(4'b0001, 4'b0001);
      chk("mid_wait_state", state_a, ST_WAIT);
      #2 reset_n = 1'b0;
      #1 chk_a_zero("async_reset_mid_wait");
      @(negedge clk) reset_n = 1'b1;
      exp_a_q.push_back(exp_a(0));
      a_start();
      chk("relaunch_start", core_start_a, 4'hF);

      // start is ignored while WAIT; batch 0 all fail, batch 4 has key 6 passing.
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      chk("start_ignored_in_wait", state_a, ST_WAIT);
      exp_a_q.push_back(exp_a(4));
      a_finish(4'b0011, 4'b0011);
      a_finish(4'b1100, 4'b1100);
      chk("check_after_last_finish", state_a, ST_CHECK);
      @(negedge clk);
      chk("relaunch_latency", core_start_a, 4'hF);
      chk("current_key_4", current_key_a, 24'd4);
      @(negedge clk);
      a_finish(4'b0100, 4'b0000);
      a_finish(4'b1011, 4'b1011);
      @(negedge clk);
      chk("found_key6", {found_a, exh_a, busy_a, found_key_a}, {1'b1, 1'b0, 1'b0, 24'd6});
      chk("found_state", state_a, ST_FOUND);
      repeat (5) @(negedge clk);
      chk("found_sticky", found_a, 1'b1);

`ifdef KEY_SEARCH_RESUME_EN
      // Resume continues with keys 8..11, which all fail and exhaust the space.
      exp_a_q.push_back(exp_a(8));
      @(negedge clk) resume_a = 1'b1;
      @(negedge clk) resume_a = 1'b0;
      chk("resume_found_cleared", found_a, 1'b0);
      chk("resume_launch", state_a, ST_LAUNCH);
      @(negedge clk);
      a_finish(4'hF, 4'hF);
      @(negedge clk);
      chk("resume_exhausted", {exh_a, found_a, state_a}, {1'b1, 1'b0, ST_EXH});
`endif

      // Back to IDLE, then keys 5 and 7 pass in the same cycle: lowest index wins.
      a_start();
      chk("start_from_done_idle", {state_a, found_a, exh_a}, {ST_IDLE, 1'b0, 1'b0});
      exp_a_q.push_back(exp_a(0));
      a_start();
      @(negedge clk);
      exp_a_q.push_back(exp_a(4));
      a_finish(4'hF, 4'hF);
      @(negedge clk);
      @(negedge clk);
      a_finish(4'hF, 4'b0101);
      @(negedge clk);
      chk("found_key5_lowest", {found_a, found_key_a}, {1'b1, 24'd5});

      // Abort during WAIT; late finishes must not revive the search.
      a_start();
      exp_a_q.push_back(exp_a(0));
      a_start();
      @(negedge clk);
      a_finish(4'b0011, 4'b0011);
      @(negedge clk) abort_a = 1'b1;
      @(negedge clk) abort_a = 1'b0;
      chk("abort_idle", {state_a, busy_a, found_a, exh_a}, {ST_IDLE, 1'b0, 1'b0, 1'b0});
      a_finish(4'hF, 4'h0);
      repeat (3) @(negedge clk);
      chk("late_finish_ignored", {state_a, found_a}, {ST_IDLE, 1'b0});

      // All keys fail: batches 0,4,8 then exhausted. A passing finish during LAUNCH is stale.
      exp_a_q.push_back(exp_a(0));
      a_start();
      for (int b = 0; b < 3; b++) begin
         if (b == 0) begin
            finish_a = 4'hF; fail_a = 4'h0;
            @(negedge clk) begin finish_a = 4'd0; fail_a = 4'd0; end
         end else begin
            @(negedge clk);
         end
         if (b < 2) exp_a_q.push_back(exp_a(4 * (b + 1)));
         a_finish(4'hF, 4'hF);
         @(negedge clk);
      end
      chk("a_exhausted", {exh_a, found_a, state_a, current_key_a}, {1'b1, 1'b0, ST_EXH, 24'd8});
      a_start();
      chk("exhausted_cleared", {exh_a, state_a}, {1'b0, ST_IDLE});

      // Instance B: 4-bit keys up to 4'hF, three cores; last batch starts only key 15.
      exp_b_q.push_back(exp_b(0));
      b_start();
      for (int base = 0; base <= 15; base += 3) begin
         @(negedge clk);
         if (base + 3 <= 15) exp_b_q.push_back(exp_b(base + 3));
         b_finish(mask_b(base), mask_b(base));
         @(negedge clk);
      end
      chk("b_exhausted", {exh_b, found_b, state_b, current_key_b}, {1'b1, 1'b0, ST_EXH, 4'hF});
      repeat (4) @(negedge clk);
      chk("b_no_wrap", {state_b, busy_b}, {ST_EXH, 1'b0});

      chk("queue_a_drained", exp_a_q.size(), 0);
      chk("queue_b_drained", exp_b_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
